fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue between instruction fetch and the instruction decoder. Buffers up to DEPTH fetched (pc, instruction) pairs so fetch can run ahead of a stalled decode. It predecodes each entry's branch class at push time and discards all contents on a redirect (BrTaken / BR).

## Interface
- DEPTH, 4, entry count; power of two, 2..16
- clk  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high; clears queue
- flush  input  1  redirect (branch taken or BR); discards all entries
- in_valid  input  1  fetch presents an entry
- in_pc  input  64  PC of the presented instruction
- in_instr  input  32  instruction word from instruction memory
- in_ready  output  1  queue can accept; `count < DEPTH`
- out_valid  output  1  head entry available; `count != 0`
- out_ready  input  1  decoder consumes head this cycle
- out_pc  output  64  head PC
- out_instr  output  32  head instruction
- out_is_br  output  1  head is B, BL, CBZ, B.cond or BR
- out_is_link  output  1  head is BL
- count  output  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: circular buffer of DEPTH entries {pc, instr, is_br, is_link}.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Push: `in_valid && in_ready && !flush` writes the entry at wr_ptr, then increments wr_ptr.
- Pop: `out_valid && out_ready && !flush` increments rd_ptr.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle are legal at any occupancy where each is individually permitted. When full, in_ready is 0, so there is no push even if a pop occurs that cycle. in_ready does not depend combinationally on out_ready.
- Predecode is computed combinationally from in_instr and stored with the entry:
  - B: instr[31:26]=000101
  - BL: instr[31:26]=100101 (also sets is_link)
  - CBZ: instr[31:24]=10110100
  - B.cond: instr[31:24]=01010100
  - BR: instr[31:21]=11010110000
  - is_br = OR of the five matches.
- Flush: next cycle rd_ptr=wr_ptr=0 and count=0. Flush has priority over a simultaneous push and pop; the pushed entry is dropped and the pop is not counted.
- Outputs out_pc, out_instr, out_is_br and out_is_link are read combinationally from the entry at rd_ptr. They are don't-care when out_valid=0, but the bench checks them only when out_valid=1.
- in_valid without in_ready, and out_ready without out_valid, are no-ops.

## Timing
- Reset: the cycle after reset is sampled high, count=0, out_valid=0, in_ready=1, and both pointers are 0. Storage contents are not reset.
- reset overrides flush and all handshakes. Reset asserted mid-operation empties the queue the same way.
- Latency: an entry pushed at edge N is visible on out_* after edge N (the same cycle as the first opportunity to pop). There is no combinational bypass from in_* to out_*, so an empty queue never shows out_valid in the push cycle.
- Throughput: one push and one pop per cycle sustained.
- Order: strict FIFO, including across pointer wrap-around.
- Flush at edge N: out_valid=0 after N. A push at N+1 is visible after N+1.
- Storage is written on posedge only; no latches.

## Structure
- Shared package fetch_pkg holds:
  - fq_entry_t packed struct {pc[63:0], instr[31:0], is_br, is_link}
  - opcode constants OP_B, OP_BL, OP_CBZ, OP_BCOND, OP_BR
  - FQ_DEPTH_DEFAULT=4
- Sub-module branch_predecode: combinational; instr[31:0] -> is_br, is_link. Reusable by the instruction decoder.
- Storage is a register array of fq_entry_t; no memory macro.

## Test plan
- Reset then idle: reset high 1 cycle -> count=0, out_valid=0, in_ready=1. Hold 5 cycles -> unchanged.
- Fill and drain, DEPTH=4, out_ready=0: push pc 0,4,8,12 (ADDI 0x91001C00 etc.) -> count=4, in_ready=0. A 5th push is ignored. Then out_ready=1 -> pcs pop 0,4,8,12 in order and count reaches 0.
- Wrap plus simultaneous push/pop: hold count=2, push and pop every cycle for 10 cycles -> count stays 2, all 10 pcs emerge in order, pointers wrap twice.
- Predecode: push 0x14000003 (B), 0x94000002 (BL), 0xB4000040 (CBZ), 0x54000040 (B.cond), 0xD61F03C0 (BR), 0x8B020020 (ADD) -> is_br=1,1,1,1,1,0 and is_link=0,1,0,0,0,0.
- Flush priority: count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0. A push of pc 64 the following cycle appears at head with count=1.
- Mid-operation reset: count=3, assert reset together with in_valid=1 -> next cycle count=0, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side types and opcode constants used by the prefetch queue and decoder.
package fetch_pkg;

  localparam int unsigned FQ_DEPTH_DEFAULT = 4;

  // Opcode fields, each compared against the top bits of the instruction word.
  localparam logic [5:0]  OP_B     = 6'b000101;       // instr[31:26]
  localparam logic [5:0]  OP_BL    = 6'b100101;       // instr[31:26]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;     // instr[31:24]
  localparam logic [7:0]  OP_BCOND = 8'b01010100;     // instr[31:24]
  localparam logic [10:0] OP_BR    = 11'b11010110000; // instr[31:21]

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        is_br;
    logic        is_link;
  } fq_entry_t;

endpackage

// File: rtl/branch_predecode.sv
// Combinational branch-class predecode of a 32-bit instruction word.
module branch_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_br,
  output logic        is_link
);

  logic match_b;
  logic match_bl;
  logic match_cbz;
  logic match_bcond;
  logic match_br;

  always_comb begin
    match_b     = (instr[31:26] == OP_B);
    match_bl    = (instr[31:26] == OP_BL);
    match_cbz   = (instr[31:24] == OP_CBZ);
    match_bcond = (instr[31:24] == OP_BCOND);
    match_br    = (instr[31:21] == OP_BR);
    is_br       = match_b | match_bl | match_cbz | match_bcond | match_br;
    is_link     = match_bl;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode; predecodes branch class on push
// and discards all contents on a redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [63:0]             in_pc,
  input  logic [31:0]             in_instr,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_pc,
  output logic [31:0]             out_instr,
  output logic                    out_is_br,
  output logic                    out_is_link,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  fq_entry_t mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;

  logic      push;
  logic      pop;
  logic      dec_is_br;
  logic      dec_is_link;
  fq_entry_t in_entry;
  fq_entry_t head;

  branch_predecode u_predecode (
    .instr   (in_instr),
    .is_br   (dec_is_br),
    .is_link (dec_is_link)
  );

  // in_ready depends only on occupancy, never on out_ready.
  assign in_ready  = (count_q < cnt_t'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    in_entry         = '0;
    in_entry.pc      = in_pc;
    in_entry.instr   = in_instr;
    in_entry.is_br   = dec_is_br;
    in_entry.is_link = dec_is_link;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; entries are only meaningful behind count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_is_br   = head.is_br;
  assign out_is_link = head.is_link;
  assign count       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_is_br;
  logic        out_is_link;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_is_br   (out_is_br),
    .out_is_link (out_is_link),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Branch classes straight from the opcode table.
  function automatic logic exp_br(input logic [31:0] ins);
    int unsigned w = ins;
    return ((w >> 26) == 32'h05) || ((w >> 26) == 32'h25) || ((w >> 24) == 32'hB4) ||
           ((w >> 24) == 32'h54) || ((w >> 21) == 32'h6B0);
  endfunction

  function automatic logic exp_link(input logic [31:0] ins);
    int unsigned w = ins;
    return (w >> 26) == 32'h25;
  endfunction

  // Applies one cycle of inputs, advances the model, leaves inputs idle.
  task automatic step(input logic rst, input logic fl, input logic iv, input logic [63:0] pc,
                      input logic [31:0] ins, input logic ordy);
    bit   p, q;
    ent_t e;
    reset = rst; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    p = iv && (mq.size() < DEPTH);
    q = ordy && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (q) void'(mq.pop_front());
      if (p) begin
        e.pc = pc;
        e.instr = ins;
        mq.push_back(e);
      end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: count=%0d out_valid=%b in_ready=%b, want 0/0/1",
               count, out_valid, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle[%0d]: count=%0d out_valid=%b in_ready=%b, want 0/0/1",
                 i, count, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_fill_drain();
    // No bypass: an empty queue shows nothing during the push cycle.
    in_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: out_valid=%b, want 0", out_valid);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 64'(4 * i), 32'h91001C00 | 32'(i), 1'b0);
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: count=%0d in_ready=%b, want 4/0", count, in_ready);
    end
    step(1'b0, 1'b0, 1'b1, 64'd16, 32'h91001C04, 1'b0);
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL push_when_full: count=%0d, want 4", count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== (32'h91001C00 | 32'(i))
          || out_is_br !== 1'b0) begin
        errors++;
        $display("FAIL drain[%0d]: valid=%b pc=%0h instr=%h br=%b, want 1/%0h/%h/0", i,
                 out_valid, out_pc, out_instr, out_is_br, 4 * i, 32'h91001C00 | 32'(i));
      end
      step(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1);
    end
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained: count=%0d out_valid=%b, want 0/0", count, out_valid);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 64'h1000, 32'h91000000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h1004, 32'h91000001, 1'b0);
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (count !== 3'd2 || out_valid !== 1'b1 || out_pc !== 64'h1000 + 64'(4 * j)) begin
        errors++;
        $display("FAIL wrap[%0d]: count=%0d pc=%0h, want 2/%0h", j, count, out_pc,
                 64'h1000 + 64'(4 * j));
      end
      step(1'b0, 1'b0, 1'b1, 64'h1000 + 64'(4 * (j + 2)), 32'h91000000 | 32'(j + 2), 1'b1);
    end
    for (int j = 10; j < 12; j++) begin
      checks++;
      if (out_pc !== 64'h1000 + 64'(4 * j)) begin
        errors++;
        $display("FAIL wrap_tail[%0d]: pc=%0h, want %0h", j, out_pc, 64'h1000 + 64'(4 * j));
      end
      step(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_empty: count=%0d, want 0", count);
    end
  endtask

  task automatic test_predecode();
    logic [31:0] ins [6] = '{32'h14000003, 32'h94000002, 32'hB4000040, 32'h54000040,
                             32'hD61F03C0, 32'h8B020020};
    logic        br  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        lnk [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 64'h2000 + 64'(4 * i), ins[i], 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== ins[i] || out_is_br !== br[i]
          || out_is_link !== lnk[i]) begin
        errors++;
        $display("FAIL predecode[%h]: valid=%b br=%b link=%b, want 1/%b/%b", ins[i],
                 out_valid, out_is_br, out_is_link, br[i], lnk[i]);
      end
      step(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 64'h3000 + 64'(4 * i), 32'h91000000, 1'b0);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_setup: count=%0d, want 3", count);
    end
    step(1'b0, 1'b1, 1'b1, 64'h3100, 32'h91000000, 1'b1);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush: count=%0d out_valid=%b, want 0/0", count, out_valid);
    end
    step(1'b0, 1'b0, 1'b1, 64'd64, 32'h94000002, 1'b0);
    checks++;
    if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 64'd64 || out_is_link !== 1'b1) begin
      errors++;
      $display("FAIL after_flush: count=%0d valid=%b pc=%0d link=%b, want 1/1/64/1",
               count, out_valid, out_pc, out_is_link);
    end
    step(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 64'h4000 + 64'(4 * i), 32'h91000000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 64'h4100, 32'h91000000, 1'b0);
    checks++;
    if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d in_ready=%b out_valid=%b, want 0/1/0",
               count, in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [63:0] pc;
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (int'(count) != mq.size() || out_valid !== (mq.size() > 0)
          || in_ready !== (mq.size() < DEPTH)) begin
        errors++;
        $display("FAIL rand_state[%0d]: count=%0d valid=%b ready=%b, want count=%0d", n,
                 count, out_valid, in_ready, mq.size());
      end
      if (mq.size() > 0) begin
        checks++;
        if (out_pc !== mq[0].pc || out_instr !== mq[0].instr
            || out_is_br !== exp_br(mq[0].instr) || out_is_link !== exp_link(mq[0].instr)) begin
          errors++;
          $display("FAIL rand_head[%0d]: pc=%0h instr=%h br=%b link=%b, want %0h/%h/%b/%b", n,
                   out_pc, out_instr, out_is_br, out_is_link, mq[0].pc, mq[0].instr,
                   exp_br(mq[0].instr), exp_link(mq[0].instr));
        end
      end
      ins = $urandom;
      case ($urandom_range(0, 6))
        0: ins[31:26] = 6'b000101;
        1: ins[31:26] = 6'b100101;
        2: ins[31:24] = 8'b10110100;
        3: ins[31:24] = 8'b01010100;
        4: ins[31:21] = 11'b11010110000;
        default: ;
      endcase
      pc = {32'h0, $urandom} & ~64'h3;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) != 0), pc, ins, ($urandom_range(0, 2) != 0));
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_predecode();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
